// File: rtl/aoc2_pkg.sv
// Shared types and defaults for the aoc2 range controller and its engine interface.
// Widths come from DATA_WIDTH / LONG_DATA_WIDTH macros when the build provides them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

package aoc2_pkg;

    typedef logic [`DATA_WIDTH-1:0]      id_t;
    typedef logic [`LONG_DATA_WIDTH-1:0] acc_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH_LO = 3'd1,
        WAIT_LO   = 3'd2,
        LAUNCH_HI = 3'd3,
        WAIT_HI   = 3'd4,
        NEXT      = 3'd5,
        DONE      = 3'd6
    } range_ctrl_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_ENG_RST_CYCLES = 2;

endpackage

// File: rtl/aoc2_range_ctrl_if.sv
// Range stream, engine and result signals of aoc2_range_ctrl in one bundle.
// master = the controller, slave = parser/engine/result side. Perf ports need AOC2_RANGE_PERF_EN.
interface aoc2_range_ctrl_if;
    import aoc2_pkg::*;

    logic in_valid;
    logic in_ready;
    id_t  in_lo;
    id_t  in_hi;
    logic in_last;

    logic eng_reset;
    id_t  eng_n;
    logic eng_valid;
    acc_t eng_count;

    logic out_valid;
    logic out_ready;
    acc_t out_sum;
    logic out_err;
    logic busy;
`ifdef AOC2_RANGE_PERF_EN
    logic [31:0] out_cycles;
    logic [15:0] out_ranges;
`endif

    modport master (
        input  in_valid, in_lo, in_hi, in_last, eng_valid, eng_count, out_ready,
`ifdef AOC2_RANGE_PERF_EN
        output out_cycles, out_ranges,
`endif
        output in_ready, eng_reset, eng_n, out_valid, out_sum, out_err, busy
    );

    modport slave (
        output in_valid, in_lo, in_hi, in_last, eng_valid, eng_count, out_ready,
`ifdef AOC2_RANGE_PERF_EN
        input  out_cycles, out_ranges,
`endif
        input  in_ready, eng_reset, eng_n, out_valid, out_sum, out_err, busy
    );

endinterface

// File: rtl/aoc2_range_ctrl.sv
// Drives count_combs twice per range (F(lo-1), F(hi)) and accumulates F(hi)-F(lo-1) per job.
// Optional AOC2_RANGE_PERF_EN adds cycle and range counters valid with out_valid.
module aoc2_range_ctrl
    import aoc2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ENG_RST_CYCLES = DEFAULT_ENG_RST_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    aoc2_range_ctrl_if.master bus
);

    localparam int RW = $clog2(ENG_RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(ENG_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

    range_ctrl_state_t state;
    id_t               hi_q;
    logic              last_q;
    acc_t              f_lo;
    acc_t              acc;
    logic              err;
    id_t               eng_n_q;
    logic [RW-1:0]     rst_cnt;
    logic [TW-1:0]     timer;
    logic              phase_hi;

    // Launch and wait logic is shared between the two operands; this bit picks which one.
    assign phase_hi = (state == LAUNCH_HI) || (state == WAIT_HI);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            hi_q    <= '0;
            last_q  <= 1'b0;
            f_lo    <= '0;
            acc     <= '0;
            err     <= 1'b0;
            eng_n_q <= '0;
            rst_cnt <= '0;
            timer   <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch sees pre-edge register values.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        hi_q    <= bus.in_hi;
                        last_q  <= bus.in_last;
                        rst_cnt <= '0;
                        if (bus.in_lo > bus.in_hi) begin
                            err   <= 1'b1;
                            state <= NEXT;
                        end else if (bus.in_lo == '0) begin
                            f_lo    <= '0;
                            eng_n_q <= bus.in_hi;
                            state   <= LAUNCH_HI;
                        end else begin
                            eng_n_q <= bus.in_lo - id_t'(1);
                            state   <= LAUNCH_LO;
                        end
                    end
                end
                LAUNCH_LO, LAUNCH_HI: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt <= '0;
                        timer   <= '0;
                        state   <= phase_hi ? WAIT_HI : WAIT_LO;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                WAIT_LO, WAIT_HI: begin
                    // A valid seen on the first wait cycle may be left over from the previous launch.
                    if (bus.eng_valid && (timer != '0)) begin
                        if (phase_hi) begin
                            acc   <= acc + bus.eng_count - f_lo;
                            state <= NEXT;
                        end else begin
                            f_lo    <= bus.eng_count;
                            eng_n_q <= hi_q;
                            state   <= LAUNCH_HI;
                        end
                    end else if (timer == TIMER_MAX) begin
                        err   <= 1'b1;
                        state <= NEXT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                NEXT: state <= last_q ? DONE : IDLE;
                DONE: begin
                    if (bus.out_ready) begin
                        acc   <= '0;
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.eng_reset = !((state == WAIT_LO) || (state == WAIT_HI));
    assign bus.eng_n     = eng_n_q;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = (state == DONE) ? acc : '0;
    assign bus.out_err   = err;
    assign bus.busy      = (state != IDLE);

`ifdef AOC2_RANGE_PERF_EN
    logic [31:0] cycles;
    logic [15:0] ranges;
    logic        job_active;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles     <= '0;
            ranges     <= '0;
            job_active <= 1'b0;
        end else if ((state == DONE) && bus.out_ready) begin
            cycles     <= '0;
            ranges     <= '0;
            job_active <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.in_valid) begin
                ranges     <= ranges + 16'd1;
                job_active <= 1'b1;
            end
            if (job_active && (state != DONE)) cycles <= cycles + 32'd1;
        end
    end

    assign bus.out_cycles = cycles;
    assign bus.out_ranges = ranges;
`endif

endmodule

// File: doc/aoc2_range_ctrl.md
Name: aoc2_range_ctrl

Overview:
- Sequencer for the `count_combs` prefix engine. `count_combs` has no start handshake; it restarts only on reset.
- Accepts a stream of ID ranges [lo, hi] and drives the engine twice per range: F(lo-1), then F(hi).
- Accumulates F(hi) - F(lo-1) into a running total and presents the total when the range flagged last completes.
- Sits between the input parser and the result register.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in a WAIT state before aborting that phase with an error.
- ENG_RST_CYCLES, 2: cycles `eng_reset` is held high per engine launch; must be ≥ 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  range available
- in_ready  out  1  controller accepts range this cycle
- in_lo  in  `DATA_WIDTH  range low bound, inclusive
- in_hi  in  `DATA_WIDTH  range high bound, inclusive
- in_last  in  1  final range of the job
- eng_reset  out  1  local reset to `count_combs`
- eng_n  out  `DATA_WIDTH  engine operand; stable for the whole launch
- eng_valid  in  1  engine `count_out_valid`
- eng_count  in  `LONG_DATA_WIDTH  engine `count_out`
- out_valid  out  1  job total valid
- out_ready  in  1  consumer accepts total
- out_sum  out  `LONG_DATA_WIDTH  accumulated total
- out_err  out  1  sticky: at least one range was invalid or timed out
- busy  out  1  state != IDLE

Behaviour:
Reset:
- State goes to IDLE.
- Outputs: `in_ready`=1, `eng_reset`=1, `eng_n`=0, `out_valid`=0, `out_sum`=0, `out_err`=0, `busy`=0.
- `reset` mid-operation drops the job; no partial `out_sum` is presented.

States:
- IDLE: `in_ready`=1, `eng_reset`=1.
  - On `in_valid`, latch lo, hi and last.
  - If lo > hi: set err and go to NEXT (range contributes 0).
  - Else if lo == 0: `f_lo`=0 and go to LAUNCH_HI.
  - Else go to LAUNCH_LO.
- LAUNCH_LO: `eng_n`=lo-1, `eng_reset`=1 for ENG_RST_CYCLES, then go to WAIT_LO.
- WAIT_LO: `eng_reset`=0.
  - On the first cycle `eng_valid`=1, capture `f_lo`=`eng_count` and go to LAUNCH_HI.
- LAUNCH_HI: `eng_n`=hi, `eng_reset`=1 for ENG_RST_CYCLES, then go to WAIT_HI.
- WAIT_HI:
  - On `eng_valid`, `acc` += `eng_count` - `f_lo` (modulo 2^`LONG_DATA_WIDTH`), then go to NEXT.
- NEXT:
  - If last, go to DONE.
  - Else go to IDLE.
- DONE: `out_valid`=1, `out_sum`=`acc`, `out_err`=err. Hold until `out_ready`.
  - On handshake, clear `acc` and err, then go to IDLE.

Timing and timeout:
- Each WAIT state has a timer cleared on entry.
- When the timer reaches TIMEOUT_CYCLES: set err, the range contributes 0, go to NEXT.
- `eng_valid` is ignored while `eng_reset`=1 and in the first WAIT cycle, to avoid stale valid from the previous launch.
- `eng_n` changes only in LAUNCH states, while `eng_reset`=1.
- Per-range latency = 2 × (ENG_RST_CYCLES + engine latency + 1) + 2 cycles; the lo==0 case saves one launch.

Handshakes:
- `in_ready` is high only in IDLE, so there is no input buffering.
- `out_valid`/`out_sum` are stable until accepted.
- A new job's first range is not accepted while in DONE.

Optional Feature:
- AOC2_RANGE_PERF_EN defined:
  - Adds `out_cycles` (32-bit) and `out_ranges` (16-bit) outputs.
  - They count cycles from the first range accepted to DONE, and ranges accepted.
  - Both are valid with `out_valid` and cleared on the output handshake.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `aoc2_pkg`:
  - state enum `range_ctrl_state_t` {IDLE, LAUNCH_LO, WAIT_LO, LAUNCH_HI, WAIT_HI, NEXT, DONE};
  - typedefs `id_t` (`DATA_WIDTH`) and `acc_t` (`LONG_DATA_WIDTH`);
  - default timeout constant.
- No sub-module; the launch/wait pair is shared logic selected by a phase bit.

Test Plan:
- Stub engine F(n)=2n, latency 5; one range lo=10, hi=20, last=1 → `eng_n` sequence 9 then 20; `out_sum`=22; `out_err`=0.
- Real `count_combs`; range 11..22, last=1 → `out_sum`=33.
- lo=0, hi=7, stub → only one launch (`eng_n`=7); `out_sum`=14.
- Three ranges (1..4, 10..10, 5..3 with last=1) → `out_sum`=8+2=10; `out_err`=1.
- Stub never asserts `eng_valid` → after TIMEOUT_CYCLES, err set; DONE reached with `out_sum`=0.
- Assert `reset` in WAIT_HI, then re-run range 10..20 → `out_sum`=22 with no residue; hold `out_ready`=0 for 5 cycles → `out_sum` stable.
